multi_operand_sum_using_fifos_and_double_buffer: RTL and testbench
==================================================================

Name: multi_operand_sum_using_fifos_and_double_buffer

Overview:
- N-channel generalisation of the two-operand FIFO adder.
- Each of n_inputs operand streams has its own valid/ready port, buffered by a per-channel flip-flop FIFO.
- When every FIFO holds an entry, one word is popped from each and the N words are summed. Overflow is wrap or saturate, selected by parameter.
- The sum and an overflow flag are registered through a double buffer to a single valid/ready output. Sits between producer streams and a downstream consumer in the homework datapath.

Parameters:
- width, 8, bits per operand and per output sum
- depth, 10, entries per channel FIFO (>=2)
- n_inputs, 4, number of operand channels (>=2)
- saturate, 0, 0 = result wraps modulo 2^width; 1 = result clamps to 2^width-1

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  n_inputs  per-channel valid; bit i = channel i
- in_ready  output  n_inputs  per-channel ready
- in_data  input  n_inputs*width  packed operands; channel i at [i*width +: width]
- sum_valid  output  1  output valid
- sum_ready  input  1  output ready
- sum_data  output  width  wrapped or saturated sum
- sum_overflow  output  1  true sum exceeded 2^width-1 (valid with sum_valid)

Behaviour:
- Reset: every FIFO empty. in_ready = all ones in the first cycle after reset deasserts. sum_valid=0, sum_data=0, sum_overflow=0.
- Reset mid-operation discards all FIFO contents and buffered sums; no partial sum survives.
- Channel i input side:
  - in_ready[i] = ~fifo_full[i].
  - Push when in_valid[i] & in_ready[i].
  - Channels are accepted independently; a full channel stalls only itself.
- Join:
  - all_valid = AND over ~fifo_empty[i].
  - Pop all FIFOs together when all_valid & buf_up_ready. No channel ever pops alone.
  - Operand order is preserved per channel: the k-th sum uses the k-th word of every channel.
- Arithmetic:
  - full_sum is width+$clog2(n_inputs) bits, zero-extended unsigned addition of all N FIFO heads.
  - overflow = |full_sum[MSBs above width].
  - saturate=0: data = full_sum[width-1:0].
  - saturate=1: data = overflow ? all ones : full_sum[width-1:0].
- Output buffer:
  - Dally-Harting double buffer of width+1 bits ({overflow, data}); up_ready is registered.
  - Sustains one sum per cycle while sum_ready=1.
  - Holds sum_valid/data stable while sum_valid & ~sum_ready.
  - Accepts at most 2 sums beyond the FIFOs when stalled.
- Latency: if all channels' operands are accepted in cycle k with the FIFOs previously empty, sum_valid=1 in cycle k+2. Throughput is 1 sum/cycle in steady state.
- Simultaneous push and pop on the same FIFO: legal in every state, including full. Push into a full FIFO is blocked by in_ready, even if a pop occurs in the same cycle.
- Wrap-around of FIFO pointers at depth-1 must be transparent, including for non-power-of-2 depth.
- Total capacity when sum_ready=0: depth words per channel plus 2 sums. The all-channels-full condition must not deadlock when sum_ready returns.

Decomposition:
- Shared package: localparam helper for sum width (width+$clog2(n_inputs)) and a packed struct {logic overflow; logic [width-1:0] data} payload type.
- Reuse the existing flip_flop_fifo_with_counter (generate loop, one per channel) and double_buffer_from_dally_harting (width+1).
- One natural new sub-module: multi_operand_adder_sat (combinational N-input sum, overflow detect, wrap/saturate select), unit-testable alone.

Test Plan:
- Basic: width=8, n_inputs=4, saturate=0. One beat per channel {10,20,30,40}, sum_ready=1 → sum_data=100, sum_overflow=0, sum_valid exactly 2 cycles after the last accept.
- Wrap: operands {200,100,50,10}, saturate=0 → sum_data=104 (360 mod 256), sum_overflow=1.
- Saturate: same operands, saturate=1 → sum_data=255, sum_overflow=1. Operands {100,100,50,5} → sum_data=255, sum_overflow=0.
- Skew/backpressure:
  - Channel 0 receives 12 beats (1..12) while the others are idle.
  - Then in_ready[0]=0 after 10 accepts (depth=10); channels 1..3 are unaffected.
  - Feed channels 1..3 with zeros → sums 1..10 emerge in order, then 11,12 after the retry.
- Output stall: stream 30 beat-sets with sum_ready toggling 1,0,0,1 randomly → no sum lost or duplicated; sum_data stable while stalled; totals match the model.
- Reset mid-flight: fill all FIFOs to 5 entries, assert rst one cycle → sum_valid=0 the next cycle, in_ready all ones. Subsequent {1,2,3,4} gives sum_data=10 with no stale data.

Source files
------------

// File: rtl/multi_operand_sum_using_fifos_and_double_buffer_pkg.sv
// Shared sizing helpers for the N-operand FIFO adder: internal sum width and
// the width of the {overflow, data} payload carried by the output buffer.
package multi_operand_sum_using_fifos_and_double_buffer_pkg;

  // Unsigned sum of n operands of w bits never needs more than w+clog2(n) bits.
  function automatic int sum_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

  // Payload layout is {overflow, data}, one bit wider than an operand.
  function automatic int payload_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/double_buffer_from_dally_harting.sv
// Two-entry pipeline buffer (main + skid register) with a registered up_ready,
// so the upstream ready path is cut while full throughput is kept.
module double_buffer_from_dally_harting #(
  parameter int W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         up_valid_i,
  output logic         up_ready_o,
  input  logic [W-1:0] up_data_i,
  output logic         down_valid_o,
  input  logic         down_ready_i,
  output logic [W-1:0] down_data_o
);
  logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic         up_ready_q, up_ready_d;
  logic         accept;

  assign accept       = up_valid_i & up_ready_q;
  assign up_ready_o   = up_ready_q;
  assign down_valid_o = main_valid_q;
  assign down_data_o  = main_data_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (~main_valid_q | down_ready_i) begin
      // up_ready is low whenever the skid is occupied, so skid and accept never coincide.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_data_d = up_data_i;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = up_data_i;
    end
    up_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      up_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      up_ready_q   <= up_ready_d;
    end
  end

endmodule

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-based FIFO with an occupancy counter; pointers wrap explicitly at
// DEPTH-1 so non-power-of-two depths work. A push into a full FIFO is dropped.
module flip_flop_fifo_with_counter #(
  parameter int W     = 8,
  parameter int DEPTH = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/multi_operand_sum_using_fifos_and_double_buffer_adder.sv
// Combinational N-operand unsigned adder with overflow detect and a
// parameter-selected wrap or saturate result.
module multi_operand_adder_sat
  import multi_operand_sum_using_fifos_and_double_buffer_pkg::*;
#(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int SAT = 0
) (
  input  logic [N*W-1:0] ops_i,
  output logic [W-1:0]   data_o,
  output logic           overflow_o
);
  localparam int SW = sum_width(W, N);

  logic [SW-1:0] full_sum;

  always_comb begin
    full_sum = '0;
    for (int i = 0; i < N; i++) full_sum = full_sum + SW'(ops_i[i*W +: W]);
  end

  assign overflow_o = |full_sum[SW-1:W];
  assign data_o     = ((SAT != 0) && overflow_o) ? {W{1'b1}} : full_sum[W-1:0];

endmodule

// File: rtl/multi_operand_sum_using_fifos_and_double_buffer.sv
// N independent operand FIFOs joined into one adder; every sum pops all FIFOs
// together and leaves through a double buffer as a {overflow, data} payload.
module multi_operand_sum_using_fifos_and_double_buffer
  import multi_operand_sum_using_fifos_and_double_buffer_pkg::*;
#(
  parameter int width    = 8,
  parameter int depth    = 10,
  parameter int n_inputs = 4,
  parameter int saturate = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [n_inputs-1:0]       in_valid,
  output logic [n_inputs-1:0]       in_ready,
  input  logic [n_inputs*width-1:0] in_data,
  output logic                      sum_valid,
  input  logic                      sum_ready,
  output logic [width-1:0]          sum_data,
  output logic                      sum_overflow
);
  localparam int PAYLOAD_W = payload_width(width);

  typedef struct packed {
    logic             overflow;
    logic [width-1:0] data;
  } payload_t;

  logic [n_inputs-1:0]       fifo_full, fifo_empty;
  logic [n_inputs*width-1:0] heads;
  logic                      all_valid, buf_up_ready, pop_all;
  payload_t                  add_out, buf_out;

  assign in_ready  = ~fifo_full;
  assign all_valid = ~|fifo_empty;
  // The join pops every channel at once; no channel ever advances alone.
  assign pop_all   = all_valid & buf_up_ready;

  for (genvar i = 0; i < n_inputs; i++) begin : g_chan
    flip_flop_fifo_with_counter #(.W(width), .DEPTH(depth)) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (in_valid[i]),
      .push_data_i(in_data[i*width +: width]),
      .pop_i      (pop_all),
      .pop_data_o (heads[i*width +: width]),
      .full_o     (fifo_full[i]),
      .empty_o    (fifo_empty[i])
    );
  end

  multi_operand_adder_sat #(.W(width), .N(n_inputs), .SAT(saturate)) u_adder (
    .ops_i     (heads),
    .data_o    (add_out.data),
    .overflow_o(add_out.overflow)
  );

  double_buffer_from_dally_harting #(.W(PAYLOAD_W)) u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .up_valid_i  (all_valid),
    .up_ready_o  (buf_up_ready),
    .up_data_i   (add_out),
    .down_valid_o(sum_valid),
    .down_ready_i(sum_ready),
    .down_data_o (buf_out)
  );

  assign sum_data     = buf_out.data;
  assign sum_overflow = buf_out.overflow;

endmodule

// File: tb/tb_multi_operand_sum_using_fifos_and_double_buffer.sv
// Bench for the N-operand FIFO adder: a wrapping and a saturating instance share
// the same stimulus and are checked against a per-channel queue model.
module tb_multi_operand_sum_using_fifos_and_double_buffer;
  localparam int W  = 8;
  localparam int D  = 10;
  localparam int N  = 4;
  localparam int SW = W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   rdy_w, rdy_s;
  logic           sv_w, sv_s, so_w, so_s;
  logic [W-1:0]   sd_w, sd_s;
  logic           rdy_dir, rdy_rand, rand_en;
  logic           sum_ready;

  assign sum_ready = rand_en ? rdy_rand : rdy_dir;

  always @(posedge clk) begin
    #1;
    rdy_rand = 1'($urandom_range(0, 1));
  end

  multi_operand_sum_using_fifos_and_double_buffer #(
    .width(W), .depth(D), .n_inputs(N), .saturate(0)
  ) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .in_data(in_data),
    .sum_valid(sv_w), .sum_ready(sum_ready), .sum_data(sd_w), .sum_overflow(so_w)
  );

  multi_operand_sum_using_fifos_and_double_buffer #(
    .width(W), .depth(D), .n_inputs(N), .saturate(1)
  ) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
    .sum_valid(sv_s), .sum_ready(sum_ready), .sum_data(sd_s), .sum_overflow(so_s)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int fired  = 0;
  logic [W-1:0]  chq [N][$];
  logic [SW-1:0] exp_q[$];
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_dw, prev_ds;
  logic          prev_ow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < N; c++) chq[c].delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(sv_w), 32'd1);
        chk("stall_data_wrap", 32'(sd_w), 32'(prev_dw));
        chk("stall_ovf_wrap", 32'(so_w), 32'(prev_ow));
        chk("stall_data_sat", 32'(sd_s), 32'(prev_ds));
      end
      for (int c = 0; c < N; c++)
        if (in_valid[c] && rdy_w[c]) chq[c].push_back(in_data[c*W +: W]);
      while (chq[0].size() > 0 && chq[1].size() > 0 && chq[2].size() > 0 && chq[3].size() > 0) begin
        logic [SW-1:0] s;
        s = '0;
        for (int c = 0; c < N; c++) s = s + SW'(chq[c].pop_front());
        exp_q.push_back(s);
      end
      if (sv_w && sum_ready) begin
        if (exp_q.size() == 0) begin
          chk("sum_without_operands", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [SW-1:0] e;
          e = exp_q.pop_front();
          chk("wrap_data", 32'(sd_w), 32'(e % 256));
          chk("wrap_ovf", 32'(so_w), 32'(e > 255));
          chk("sat_valid", 32'(sv_s), 32'd1);
          chk("sat_data", 32'(sd_s), (e > 255) ? 32'd255 : 32'(e));
          chk("sat_ovf", 32'(so_s), 32'(e > 255));
        end
        fired++;
      end
      prev_stall = sv_w & ~sum_ready;
      prev_dw    = sd_w;
      prev_ow    = so_w;
      prev_ds    = sd_s;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds each masked channel valid until it is accepted, independently.
  task automatic send_set(input logic [N-1:0] mask, input logic [N*W-1:0] d);
    logic [N-1:0] pending, acc;
    int cyc;
    pending  = mask;
    in_data  = d;
    in_valid = pending;
    cyc      = 0;
    while (pending != '0 && cyc < 200) begin
      @(negedge clk);
      acc = pending & rdy_w;
      tick();
      pending  = pending & ~acc;
      in_valid = pending;
      cyc++;
    end
    if (pending != '0) chk("send_timeout", 32'(pending), 32'd0);
    in_valid = '0;
  endtask

  task automatic wait_sum(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!sv_w && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(sv_w), 32'd1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || sv_w || chq[0].size() != 0) && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    rdy_dir  = 1'b1;
    rand_en  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    @(negedge clk);
    chk("reset_in_ready", 32'(rdy_w), 32'hF);
    chk("reset_in_ready_sat", 32'(rdy_s), 32'hF);
    chk("reset_sum_valid", 32'(sv_w), 32'd0);
    chk("reset_sum_data", 32'(sd_w), 32'd0);
    chk("reset_sum_ovf", 32'(so_w), 32'd0);
    tick();

    // basic sum and two-cycle latency
    in_valid = 4'hF;
    in_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    tick();
    in_valid = '0;
    @(negedge clk);
    chk("latency_k1_not_valid", 32'(sv_w), 32'd0);
    tick();
    @(negedge clk);
    chk("latency_k2_valid", 32'(sv_w), 32'd1);
    chk("basic_data", 32'(sd_w), 32'd100);
    chk("basic_ovf", 32'(so_w), 32'd0);
    tick();

    // wrap vs saturate on overflow
    send_set(4'hF, {8'd10, 8'd50, 8'd100, 8'd200});
    wait_sum("wrap_case_valid");
    chk("wrap_case_data", 32'(sd_w), 32'd104);
    chk("wrap_case_ovf", 32'(so_w), 32'd1);
    chk("sat_case_data", 32'(sd_s), 32'd255);
    chk("sat_case_ovf", 32'(so_s), 32'd1);
    tick();

    // exactly 255: no overflow on either instance
    send_set(4'hF, {8'd5, 8'd50, 8'd100, 8'd100});
    wait_sum("edge255_valid");
    chk("edge255_wrap_data", 32'(sd_w), 32'd255);
    chk("edge255_wrap_ovf", 32'(so_w), 32'd0);
    chk("edge255_sat_ovf", 32'(so_s), 32'd0);
    tick();

    // skew: channel 0 alone fills to depth, others stay ready
    for (int i = 1; i <= D; i++) send_set(4'h1, (N*W)'(i));
    @(negedge clk);
    chk("skew_ch0_full", 32'(rdy_w[0]), 32'd0);
    chk("skew_others_ready", 32'(rdy_w[3:1]), 32'd7);
    chk("skew_no_sum", 32'(sv_w), 32'd0);
    tick();
    send_set(4'hF, {8'd0, 8'd0, 8'd0, 8'd11});
    send_set(4'hF, {8'd0, 8'd0, 8'd0, 8'd12});
    for (int i = 0; i < D; i++) send_set(4'hE, '0);
    drain();

    // random data with random output backpressure
    rand_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [N*W-1:0] d;
      for (int c = 0; c < N; c++) d[c*W +: W] = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) tick();
      send_set(4'hF, d);
    end
    rand_en = 1'b0;
    drain();
    chk("total_sums", 32'(fired), 32'd45);

    // reset in the middle of a stalled backlog
    rdy_dir = 1'b0;
    for (int i = 0; i < 7; i++) send_set(4'hF, {8'd9, 8'd9, 8'd9, 8'd9});
    tick();
    @(negedge clk);
    chk("pre_reset_held", 32'(sv_w), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", 32'(sv_w), 32'd0);
    chk("post_reset_in_ready", 32'(rdy_w), 32'hF);
    chk("post_reset_data", 32'(sd_w), 32'd0);
    tick();
    rdy_dir = 1'b1;
    send_set(4'hF, {8'd4, 8'd3, 8'd2, 8'd1});
    wait_sum("after_reset_valid");
    chk("after_reset_data", 32'(sd_w), 32'd10);
    chk("after_reset_ovf", 32'(so_w), 32'd0);
    tick();
    drain();
    chk("no_stale_sum", 32'(sv_w), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
